// File: rtl/store_buffer.sv
// store_buffer: pending-store FIFO between the EX/MEM register and dataMemory.
// Stores are drained to memory one per cycle when no load needs the port.
// Loads return data one cycle after they are accepted.
// Optional feature macro: STORE_FWD_EN (store-to-load forwarding).
//   Defined     : loads never stall; a buffered store to the same address is
//                 forwarded, otherwise memory is read.
//   Not defined : a load stalls while entries are pending and reads memory
//                 once the buffer is empty.
module store_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  storeReqM,
  input  logic                  loadReqM,
  input  logic [ADDR_WIDTH-1:0] ALUMemAdd,
  input  logic [DATA_WIDTH-1:0] writeDataM,
  output logic                  stallM,
  output logic                  memWriteEn,
  output logic                  memReadEn,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memWriteData,
  input  logic [DATA_WIDTH-1:0] memReadData,
  output logic [DATA_WIDTH-1:0] loadDataW,
  output logic                  loadValidW,
  output logic [CNT_WIDTH-1:0]  bufCount
);

  localparam int PTR_W = CNT_WIDTH - 1;

  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_loadValid;
  logic                  r_hit;
  logic [DATA_WIDTH-1:0] r_fwd;
  logic [DATA_WIDTH-1:0] r_loadData;

  logic                  w_load;
  logic                  w_full;
  logic                  w_storeAcc;
  logic                  w_loadAcc;
  logic                  w_rd;
  logic                  w_drain;
  logic                  w_hit;
  logic [DATA_WIDTH-1:0] w_fwdData;
  logic [DATA_WIDTH-1:0] w_loadOut;

  // A simultaneous store wins; the load half of the request is dropped.
  assign w_load     = loadReqM & ~storeReqM;
  assign w_full     = (r_count == CNT_WIDTH'(DEPTH));
  assign w_storeAcc = storeReqM & ~w_full;

`ifdef STORE_FWD_EN
  logic [PTR_W-1:0] w_idx;

  // Scan oldest to youngest so the youngest matching entry is the one kept.
  always_comb begin
    w_hit     = 1'b0;
    w_fwdData = '0;
    w_idx     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if ((CNT_WIDTH'(i) < r_count) && (r_addr[w_idx] == ALUMemAdd)) begin
        w_hit     = 1'b1;
        w_fwdData = r_data[w_idx];
      end
    end
  end

  assign w_loadAcc = w_load;
  assign w_rd      = w_load & ~w_hit;
  assign stallM    = storeReqM & w_full;
`else
  assign w_hit     = 1'b0;
  assign w_fwdData = '0;
  assign w_loadAcc = w_load & (r_count == '0);
  assign w_rd      = w_loadAcc;
  assign stallM    = (storeReqM & w_full) | (w_load & (r_count != '0));
`endif

  assign w_drain      = (r_count != '0) & ~w_rd;
  assign memReadEn    = w_rd;
  assign memWriteEn   = w_drain;
  assign memAddr      = w_rd    ? ALUMemAdd      :
                        w_drain ? r_addr[r_head] : '0;
  assign memWriteData = w_drain ? r_data[r_head] : '0;

  // Hit flag chosen at request time selects forwarded data or the memory read.
  assign w_loadOut  = r_hit ? r_fwd : memReadData;
  assign loadDataW  = r_loadValid ? w_loadOut : r_loadData;
  assign loadValidW = r_loadValid;
  assign bufCount   = r_count;

  // Entry payload written at the tail on an accepted store.
  always_ff @(posedge CLK) begin
    if (!RST && w_storeAcc) begin
      r_addr[r_tail] <= ALUMemAdd;
      r_data[r_tail] <= writeDataM;
    end
  end

  // Pointers, occupancy and load-return state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_loadValid <= 1'b0;
      r_hit       <= 1'b0;
      r_fwd       <= '0;
      r_loadData  <= '0;
    end else begin
      if (w_storeAcc) r_tail <= r_tail + PTR_W'(1);
      if (w_drain)    r_head <= r_head + PTR_W'(1);
      case ({w_storeAcc, w_drain})
        2'b10:   r_count <= r_count + CNT_WIDTH'(1);
        2'b01:   r_count <= r_count - CNT_WIDTH'(1);
        default: r_count <= r_count;
      endcase
      r_loadValid <= w_loadAcc;
      if (w_loadAcc) begin
        r_hit <= w_hit;
        r_fwd <= w_fwdData;
      end
      if (r_loadValid) r_loadData <= w_loadOut;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: randomized bench for store_buffer with a queue-based
// reference model and a simple registered-read data memory.
module tb_store_buffer;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          storeReqM = 1'b0;
  logic          loadReqM = 1'b0;
  logic [AW-1:0] ALUMemAdd = '0;
  logic [DW-1:0] writeDataM = '0;
  logic          stallM;
  logic          memWriteEn;
  logic          memReadEn;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWriteData;
  logic [DW-1:0] memReadData;
  logic [DW-1:0] loadDataW;
  logic          loadValidW;
  logic [CW-1:0] bufCount;

  always #5 CLK = ~CLK;

  store_buffer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .CNT_WIDTH(CW)
  ) dut (
    .CLK(CLK), .RST(RST),
    .storeReqM(storeReqM), .loadReqM(loadReqM),
    .ALUMemAdd(ALUMemAdd), .writeDataM(writeDataM),
    .stallM(stallM), .memWriteEn(memWriteEn), .memReadEn(memReadEn),
    .memAddr(memAddr), .memWriteData(memWriteData), .memReadData(memReadData),
    .loadDataW(loadDataW), .loadValidW(loadValidW), .bufCount(bufCount)
  );

  // Data memory: registered read, ignores the port while reset is held.
  logic [DW-1:0] dmem   [256];
  logic [DW-1:0] refmem [256];
  always @(posedge CLK) begin
    if (!RST) begin
      if (memWriteEn) dmem[memAddr[7:0]] <= memWriteData;
      if (memReadEn)  memReadData <= dmem[memAddr[7:0]];
    end
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] last_load = '0;
  bit            last_stall = 1'b0;
  int            n_total = 0;
  int            n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus; the model predicts every output from the queue.
  task automatic step(input bit st, input bit ld, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int            cnt;
    bit            load, hit, e_rd, e_wr, e_stall, acc;
    logic [DW-1:0] fdata, e_load;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    @(negedge CLK);
    storeReqM = st; loadReqM = ld; ALUMemAdd = a; writeDataM = d;
    #1;
    cnt = q.size();
    load = ld && !st;
    hit = 1'b0;
    fdata = '0;
`ifdef STORE_FWD_EN
    foreach (q[i]) if (q[i].a == a) begin hit = 1'b1; fdata = q[i].d; end
    e_rd    = load && !hit;
    acc     = load;
    e_stall = st && (cnt == DEPTH);
`else
    e_rd    = load && (cnt == 0);
    acc     = e_rd;
    e_stall = (st && (cnt == DEPTH)) || (load && (cnt > 0));
`endif
    e_wr    = (cnt > 0) && !e_rd;
    e_addr  = e_rd ? a : (e_wr ? q[0].a : '0);
    e_wdata = e_wr ? q[0].d : '0;
    chk("stallM", 32'(stallM), 32'(e_stall));
    chk("memReadEn", 32'(memReadEn), 32'(e_rd));
    chk("memWriteEn", 32'(memWriteEn), 32'(e_wr));
    chk("memAddr", memAddr, e_addr);
    chk("memWriteData", memWriteData, e_wdata);
    e_load = hit ? fdata : refmem[a[7:0]];
    if (e_wr) begin
      refmem[q[0].a[7:0]] = q[0].d;
      void'(q.pop_front());
    end
    if (st && cnt < DEPTH) q.push_back('{a: a, d: d});
    @(posedge CLK);
    #1;
    chk("loadValidW", 32'(loadValidW), 32'(acc));
    if (acc) last_load = e_load;
    chk("loadDataW", loadDataW, last_load);
    chk("bufCount", 32'(bufCount), 32'(q.size()));
    last_stall = e_stall;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; storeReqM = 1'b0; loadReqM = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    q.delete();
    last_load = '0;
    last_stall = 1'b0;
    chk("rst_bufCount", 32'(bufCount), 32'd0);
    chk("rst_loadValidW", 32'(loadValidW), 32'd0);
    chk("rst_loadDataW", loadDataW, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit            st, ld;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            tries;
    for (int i = 0; i < 256; i++) begin dmem[i] = '0; refmem[i] = '0; end
    do_reset();
    step(1'b0, 1'b0, '0, '0);

    // Back-to-back stores to 1..5, retrying while stalled.
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b0, AW'(k), DW'(32'h11 * k));
      tries = 0;
      while (last_stall && tries < 8) begin
        step(1'b1, 1'b0, AW'(k), DW'(32'h11 * k));
        tries++;
      end
    end
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, '0, '0);
    for (int k = 1; k <= 5; k++) chk("fill_mem", dmem[k], 32'h11 * k);

`ifdef STORE_FWD_EN
    // Two stores to the same address, then a load while buffered.
    step(1'b1, 1'b0, 32'd7, 32'hAA);
    step(1'b1, 1'b0, 32'd7, 32'hBB);
    step(1'b0, 1'b1, 32'd7, '0);
    chk("fwd_data", loadDataW, 32'hBB);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, '0, '0);
`endif

    // Load miss against a preloaded memory word.
    dmem[3] = 32'h1234; refmem[3] = 32'h1234;
    step(1'b1, 1'b0, 32'd10, 32'h5A5A);
    step(1'b1, 1'b0, 32'd11, 32'h6B6B);
    tries = 0;
    step(1'b0, 1'b1, 32'd3, '0);
    while (last_stall && tries < 8) begin
      step(1'b0, 1'b1, 32'd3, '0);
      tries++;
    end
    chk("miss_data", loadDataW, 32'h1234);
    chk("miss_bound", 32'(tries < 8), 32'd1);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, '0, '0);

    // Reset while a store is still buffered: it must never reach memory.
    step(1'b1, 1'b0, 32'd20, 32'hC0DE);
    step(1'b1, 1'b0, 32'd21, 32'hBEEF);
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, '0, '0);
    chk("rst_no_write", dmem[21], 32'd0);

    // Randomized traffic; stalled requests are held and retried.
    st = 1'b0; ld = 1'b0; a = '0; d = '0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 63) == 0) begin
        do_reset();
      end else begin
        if (!last_stall) begin
          st = ($urandom_range(0, 99) < 40);
          ld = ($urandom_range(0, 99) < 45);
          a  = AW'($urandom_range(0, 7));
          d  = $urandom;
        end
        step(st, ld, a, d);
      end
    end
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 8; i++) chk("final_mem", dmem[i], refmem[i]);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
